// File: rtl/d_memory_ls_if.sv
// Request/response bundle for the MEM-stage data memory.
// The master side issues requests; the slave side is the memory itself.
interface d_memory_ls_if #(
    parameter int unsigned WORDLENGTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [WORDLENGTH-1:0] req_addr;
    logic [WORDLENGTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [WORDLENGTH-1:0] resp_rdata;
    logic                  resp_err;
    logic                  init_done;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, init_done
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, init_done
    );
endinterface

// File: rtl/d_memory_ls.sv
// Little-endian byte-addressable data memory with byte/half/word loads and stores,
// fixed-latency in-order responses, access error detection and a post-reset zero sweep.
module d_memory_ls #(
    parameter int unsigned WORDLENGTH   = 32,
    parameter int unsigned DMEM_SIZE    = 1024,
    parameter int unsigned READ_LATENCY = 1
) (
    input logic         clk,
    input logic         reset,
    d_memory_ls_if.slave bus
);
    localparam int unsigned AW = $clog2(DMEM_SIZE);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_e;

    state_e          state_q;
    logic [AW-1:0]   ptr_q;
    logic            ready_q;
    logic            done_q;
    logic [7:0]      mem_q [DMEM_SIZE];

    logic            pv_q [READ_LATENCY];
    logic [WORDLENGTH-1:0] pd_q [READ_LATENCY];
    logic            pe_q [READ_LATENCY];

    logic [2:0]      nbytes;
    logic [3:0]      byte_en;
    logic            misaligned;
    logic            out_of_range;
    logic            size_bad;
    logic            err;
    logic            accept;
    logic [AW-1:0]   base;
    logic [7:0]      lane [4];
    logic            sgn_b;
    logic            sgn_h;
    logic [WORDLENGTH-1:0] load_d;

    assign accept = bus.req_valid && ready_q;
    assign base   = bus.req_addr[AW-1:0];

    // Range test is widened by one bit so addresses near the top of the space cannot wrap.
    always_comb begin
        nbytes  = 3'd4;
        byte_en = 4'b1111;
        case (bus.req_size)
            2'b00: begin nbytes = 3'd1; byte_en = 4'b0001; end
            2'b01: begin nbytes = 3'd2; byte_en = 4'b0011; end
            default: begin nbytes = 3'd4; byte_en = 4'b1111; end
        endcase
        size_bad     = (bus.req_size == 2'b11);
        misaligned   = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                       ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
        out_of_range = ({1'b0, bus.req_addr} + (WORDLENGTH+1)'(nbytes)) >
                       (WORDLENGTH+1)'(DMEM_SIZE);
        err          = size_bad || misaligned || out_of_range;
    end

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            lane[i] = mem_q[base + AW'(i)];
        end
    end

    always_comb begin
        sgn_b  = !bus.req_unsigned && lane[0][7];
        sgn_h  = !bus.req_unsigned && lane[1][7];
        load_d = '0;
        if (!err && !bus.req_we) begin
            case (bus.req_size)
                2'b00:   load_d = {{(WORDLENGTH-8){sgn_b}}, lane[0]};
                2'b01:   load_d = {{(WORDLENGTH-16){sgn_h}}, lane[1], lane[0]};
                2'b10:   load_d = {lane[3], lane[2], lane[1], lane[0]};
                default: load_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_INIT;
            ptr_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_INIT: begin
                    ptr_q <= ptr_q + AW'(4);
                    if (ptr_q == AW'(DMEM_SIZE - 4)) begin
                        state_q <= S_RUN;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    ready_q <= 1'b1;
                    done_q  <= 1'b1;
                end
            endcase
        end
    end

    // Storage has no reset; the INIT sweep clears it one word per cycle instead.
    always_ff @(posedge clk) begin
        if (state_q == S_INIT) begin
            for (int unsigned i = 0; i < 4; i++) begin
                mem_q[ptr_q + AW'(i)] <= '0;
            end
        end else if (accept && bus.req_we && !err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem_q[base + AW'(i)] <= bus.req_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                pv_q[i] <= 1'b0;
                pd_q[i] <= '0;
                pe_q[i] <= 1'b0;
            end
        end else begin
            pv_q[0] <= accept;
            pd_q[0] <= accept ? load_d : '0;
            pe_q[0] <= accept && err;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                pv_q[i] <= pv_q[i-1];
                pd_q[i] <= pd_q[i-1];
                pe_q[i] <= pe_q[i-1];
            end
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.init_done  = done_q;
    assign bus.resp_valid = pv_q[READ_LATENCY-1];
    assign bus.resp_rdata = pd_q[READ_LATENCY-1];
    assign bus.resp_err   = pe_q[READ_LATENCY-1];
endmodule

// File: tb/tb_d_memory_ls.sv
// Bench for d_memory_ls: two instances (latency 1 and 3) driven in lockstep, checked
// against a byte-array reference model and a table of hand-computed vectors.
module tb_d_memory_ls;
    localparam int unsigned W  = 32;
    localparam int unsigned SZ = 1024;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    d_memory_ls_if #(.WORDLENGTH(W)) bus1 ();
    d_memory_ls_if #(.WORDLENGTH(W)) bus3 ();

    d_memory_ls #(.WORDLENGTH(W), .DMEM_SIZE(SZ), .READ_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );
    d_memory_ls #(.WORDLENGTH(W), .DMEM_SIZE(SZ), .READ_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3)
    );

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    exp_t        q1[$];
    exp_t        q3[$];
    vec_t        tbl[$];
    logic [7:0]  ref_mem [SZ];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        running = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, req);
        end
    endtask

    task automatic monitor();
        exp_t x;
        if (q1.size() > 0 && q1[0].due == cyc) begin
            x = q1.pop_front();
            chk("resp_rl1", 64'({bus1.resp_valid, bus1.resp_err, bus1.resp_rdata}),
                64'({1'b1, x.err, x.rdata}));
        end else begin
            chk("idle_rl1", 64'(bus1.resp_valid), 64'(0));
        end
        if (q3.size() > 0 && q3[0].due == cyc) begin
            x = q3.pop_front();
            chk("resp_rl3", 64'({bus3.resp_valid, bus3.resp_err, bus3.resp_rdata}),
                64'({1'b1, x.err, x.rdata}));
        end else begin
            chk("idle_rl3", 64'(bus3.resp_valid), 64'(0));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        monitor();
    endtask

    task automatic drive(input logic v, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus1.req_valid = v; bus1.req_we = we; bus1.req_size = size;
        bus1.req_unsigned = uns; bus1.req_addr = addr; bus1.req_wdata = wdata;
        bus3.req_valid = v; bus3.req_we = we; bus3.req_size = size;
        bus3.req_unsigned = uns; bus3.req_addr = addr; bus3.req_wdata = wdata;
    endtask

    // Reference: a flat byte array, little-endian assembly and arithmetic sign extension.
    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic e);
        longint a;
        longint v;
        int     n;
        n  = 1 << size;
        a  = longint'(addr);
        e  = (size == 2'd3) || (a % n != 0) || (a + n > SZ);
        rd = '0;
        if (!e) begin
            if (we) begin
                for (int i = 0; i < n; i++) ref_mem[a + i] = wdata[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < n; i++) v += longint'(ref_mem[a + i]) << (8 * i);
                if (!uns && n < 4 && v[8*n-1]) v -= longint'(1) << (8 * n);
                rd = v[31:0];
            end
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] er, input logic ee);
        drive(1'b1, we, size, uns, addr, wdata);
        if (running) begin
            q1.push_back('{cyc + 1, er, ee});
            q3.push_back('{cyc + 3, er, ee});
        end
        tick();
    endtask

    task automatic issue_model(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] rd;
        logic        e;
        model(we, size, uns, addr, wdata, rd, e);
        issue(we, size, uns, addr, wdata, rd, e);
    endtask

    task automatic reset_outputs_zero(input string name);
        chk({name, "_rl1"}, 64'({bus1.req_ready, bus1.resp_valid, bus1.resp_err,
                                 bus1.init_done, bus1.resp_rdata}), 64'(0));
        chk({name, "_rl3"}, 64'({bus3.req_ready, bus3.resp_valid, bus3.resp_err,
                                 bus3.init_done, bus3.resp_rdata}), 64'(0));
    endtask

    // A store held valid during the sweep must be ignored, since nothing is ready to take it.
    task automatic init_wait();
        int k;
        k = 0;
        drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h20, 32'hFFFF_FFFF);
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (bus1.init_done) begin
                k = i;
                break;
            end
            chk("ready_in_init", 64'({bus1.req_ready, bus3.req_ready}), 64'(0));
        end
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        chk("init_cycles", 64'(k), 64'(SZ / 4));
        chk("run_flags", 64'({bus1.req_ready, bus3.req_ready, bus3.init_done}), 64'(3'b111));
        for (int i = 0; i < SZ; i++) ref_mem[i] = 8'h00;
        running = 1'b1;
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic err);
        vec_t t;
        t.we = we; t.size = size; t.uns = uns; t.addr = addr;
        t.wdata = wdata; t.rdata = rdata; t.err = err;
        return t;
    endfunction

    initial begin
        logic [31:0] rd;
        logic        e;
        logic [1:0]  sz;
        logic [31:0] ad;
        int          r;

        tbl.push_back(mk(0, 2'd2, 0, 32'h3FC, 32'h0,         32'h0000_0000, 0));
        tbl.push_back(mk(0, 2'd2, 0, 32'h020, 32'h0,         32'h0000_0000, 0));
        tbl.push_back(mk(1, 2'd2, 0, 32'h010, 32'hDEADBEEF,  32'h0000_0000, 0));
        tbl.push_back(mk(0, 2'd0, 0, 32'h010, 32'h0,         32'hFFFF_FFEF, 0));
        tbl.push_back(mk(0, 2'd0, 1, 32'h013, 32'h0,         32'h0000_00DE, 0));
        tbl.push_back(mk(0, 2'd1, 0, 32'h012, 32'h0,         32'hFFFF_DEAD, 0));
        tbl.push_back(mk(1, 2'd0, 0, 32'h011, 32'h0000_007F, 32'h0000_0000, 0));
        tbl.push_back(mk(0, 2'd2, 0, 32'h010, 32'h0,         32'hDEAD_7FEF, 0));
        tbl.push_back(mk(1, 2'd2, 0, 32'h002, 32'h1234_5678, 32'h0000_0000, 1));
        tbl.push_back(mk(0, 2'd2, 0, 32'h000, 32'h0,         32'h0000_0000, 0));
        tbl.push_back(mk(0, 2'd2, 0, 32'h004, 32'h0,         32'h0000_0000, 0));
        tbl.push_back(mk(0, 2'd1, 0, 32'h3FF, 32'h0,         32'h0000_0000, 1));
        tbl.push_back(mk(0, 2'd2, 0, 32'h400, 32'h0,         32'h0000_0000, 1));
        tbl.push_back(mk(0, 2'd3, 0, 32'h020, 32'h0,         32'h0000_0000, 1));
        tbl.push_back(mk(1, 2'd1, 0, 32'h3FE, 32'hAAAA_8001, 32'h0000_0000, 0));
        tbl.push_back(mk(0, 2'd1, 0, 32'h3FE, 32'h0,         32'hFFFF_8001, 0));
        tbl.push_back(mk(0, 2'd1, 1, 32'h3FE, 32'h0,         32'h0000_8001, 0));
        tbl.push_back(mk(0, 2'd0, 1, 32'h3FF, 32'h0,         32'h0000_0080, 0));
        tbl.push_back(mk(0, 2'd2, 0, 32'hFFFF_FFFC, 32'h0,   32'h0000_0000, 1));
        tbl.push_back(mk(0, 2'd0, 0, 32'h3FE, 32'h0,         32'h0000_0001, 0));

        reset = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        #1;
        reset_outputs_zero("reset_state");
        repeat (3) tick();
        reset = 1'b1;
        init_wait();

        foreach (tbl[i]) begin
            model(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, rd, e);
            issue(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
                  tbl[i].rdata, tbl[i].err);
        end

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
                tick();
            end else begin
                r  = int'($urandom_range(0, 9));
                sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
                r  = int'($urandom_range(0, 9));
                if (r < 7)      ad = 32'h100 + $urandom_range(0, 31);
                else if (r < 9) ad = $urandom_range(0, SZ + 7);
                else            ad = $urandom;
                issue_model(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                            ad, $urandom);
            end
        end
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        repeat (4) tick();
        chk("drained", 64'(q1.size() + q3.size()), 64'(0));

        // Two loads in flight on the latency-3 instance when reset hits.
        issue_model(1'b0, 2'd2, 1'b0, 32'h010, 32'h0);
        issue_model(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        reset = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        q1.delete();
        q3.delete();
        running = 1'b0;
        #1;
        reset_outputs_zero("midreset");
        repeat (4) tick();
        reset = 1'b1;
        init_wait();

        issue_model(1'b0, 2'd2, 1'b0, 32'h010, 32'h0);
        issue_model(1'b0, 2'd1, 1'b1, 32'h3FE, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h0, 1'b0);
        issue(1'b1, 2'd2, 1'b0, 32'h200, 32'h8123_4567, 32'h0, 1'b0);
        issue(1'b0, 2'd0, 1'b0, 32'h203, 32'h0, 32'hFFFF_FF81, 1'b0);
        issue(1'b0, 2'd1, 1'b1, 32'h200, 32'h0, 32'h0000_4567, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 32'h8123_4567, 1'b0);
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        repeat (4) tick();
        chk("drained_end", 64'(q1.size() + q3.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
